// File: rtl/game_board.sv
// Player Sudoku board for one round: snapshots the selected map/visibility on load,
// builds the board serially, takes cursor/digit edits, then rescans against the solution.
module game_board (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [161:0] selected_visibility,
  input  logic [323:0] selected_map,
  input  logic         move_up,
  input  logic         move_down,
  input  logic         move_left,
  input  logic         move_right,
  input  logic         write_en,
  input  logic [3:0]   write_value,
  input  logic         clear_cell,
  output logic [323:0] board,
  output logic [80:0]  given_mask,
  output logic [3:0]   cursor_row,
  output logic [3:0]   cursor_col,
  output logic         busy,
  output logic         solved,
  output logic [6:0]   wrong_count
);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, CHECK, SOLVED} state_t;

  state_t       state, next_state;
  logic [323:0] solution;
  logic [6:0]   idx, wrong_cnt, empty_cnt;
  logic [6:0]   cur_cell, wrong_total, empty_total;
  logic [8:0]   cur_base, scan_base;
  logic [3:0]   scan_board, scan_sol, next_row, next_col;
  logic         cur_given, scan_last, write_ok, clear_ok, move_req;
  logic         unused_vis_odd;

  // Odd visibility bits carry no meaning for the board.
  always_comb begin
    unused_vis_odd = 1'b0;
    for (int unsigned k = 0; k < 81; k++) begin
      unused_vis_odd = unused_vis_odd ^ selected_visibility[2*k+1];
    end
  end

  always_comb begin
    cur_cell    = {3'b000, cursor_row} * 7'd9 + {3'b000, cursor_col};
    cur_base    = {cur_cell, 2'b00};
    scan_base   = {idx, 2'b00};
    cur_given   = given_mask[cur_cell];
    scan_board  = board[scan_base +: 4];
    scan_sol    = solution[scan_base +: 4];
    scan_last   = (idx == 7'd80);
    wrong_total = wrong_cnt + {6'b0, (scan_board != 4'd0) && (scan_board != scan_sol)};
    empty_total = empty_cnt + {6'b0, scan_board == 4'd0};
  end

  always_comb begin
    next_row = cursor_row;
    next_col = cursor_col;
    if (move_up)         next_row = (cursor_row == 4'd0) ? 4'd8 : cursor_row - 4'd1;
    else if (move_down)  next_row = (cursor_row == 4'd8) ? 4'd0 : cursor_row + 4'd1;
    else if (move_left)  next_col = (cursor_col == 4'd0) ? 4'd8 : cursor_col - 4'd1;
    else if (move_right) next_col = (cursor_col == 4'd8) ? 4'd0 : cursor_col + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (load) begin
      next_state = LOAD;
    end else begin
      case (state)
        LOAD:    if (scan_last) next_state = PLAY;
        PLAY:    if (write_ok || clear_ok) next_state = CHECK;
        CHECK:   if (scan_last)
                   next_state = (wrong_total == 7'd0 && empty_total == 7'd0) ? SOLVED : PLAY;
        default: next_state = state;
      endcase
    end
  end

  // A rejected write still consumes the cycle, so a simultaneous move is dropped.
  always_comb begin
    write_ok = (state == PLAY) && write_en && !cur_given &&
               (write_value >= 4'd1) && (write_value <= 4'd9);
    clear_ok = (state == PLAY) && !write_en && clear_cell && !cur_given;
    move_req = ((state == PLAY) && !write_en && !clear_cell) || (state == SOLVED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board       <= '0;
      given_mask  <= '0;
      solution    <= '0;
      cursor_row  <= '0;
      cursor_col  <= '0;
      busy        <= 1'b0;
      solved      <= 1'b0;
      wrong_count <= '0;
      idx         <= '0;
      wrong_cnt   <= '0;
      empty_cnt   <= '0;
    end else begin
      busy <= (next_state == LOAD) || (next_state == CHECK);
      if (load) begin
        solution <= selected_map;
        for (int unsigned k = 0; k < 81; k++) begin
          given_mask[k] <= selected_visibility[2*k];
        end
        idx         <= '0;
        cursor_row  <= '0;
        cursor_col  <= '0;
        solved      <= 1'b0;
        wrong_count <= '0;
        wrong_cnt   <= '0;
        empty_cnt   <= '0;
      end else begin
        case (state)
          LOAD: begin
            board[scan_base +: 4] <= given_mask[idx] ? scan_sol : 4'd0;
            idx <= scan_last ? 7'd0 : idx + 7'd1;
          end
          PLAY: begin
            if (write_ok || clear_ok) begin
              board[cur_base +: 4] <= write_ok ? write_value : 4'd0;
              idx       <= '0;
              wrong_cnt <= '0;
              empty_cnt <= '0;
            end
          end
          CHECK: begin
            wrong_cnt <= wrong_total;
            empty_cnt <= empty_total;
            idx       <= idx + 7'd1;
            if (scan_last) begin
              wrong_count <= wrong_total;
              solved      <= (wrong_total == 7'd0) && (empty_total == 7'd0);
              idx         <= '0;
            end
          end
          default: ;
        endcase
        if (move_req) begin
          cursor_row <= next_row;
          cursor_col <= next_col;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_board.sv
// Directed bench for game_board: load timing, edits, scan results, wrap, aborts and reset.
module tb_game_board;

  logic         clk = 1'b0;
  logic         reset, load;
  logic [161:0] selected_visibility;
  logic [323:0] selected_map;
  logic         move_up, move_down, move_left, move_right, write_en, clear_cell;
  logic [3:0]   write_value;
  logic [323:0] board;
  logic [80:0]  given_mask;
  logic [3:0]   cursor_row, cursor_col;
  logic         busy, solved;
  logic [6:0]   wrong_count;

  int checks = 0;
  int errors = 0;

  logic [323:0] map_a, map_b, exp_board;
  logic [161:0] vis_all, vis_hide0;
  logic [80:0]  mask_all, mask_hide0;
  int           n;

  always #5 clk = ~clk;

  game_board dut (
    .clk(clk), .reset(reset), .load(load),
    .selected_visibility(selected_visibility), .selected_map(selected_map),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .write_en(write_en), .write_value(write_value), .clear_cell(clear_cell),
    .board(board), .given_mask(given_mask), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .busy(busy), .solved(solved), .wrong_count(wrong_count)
  );

  task automatic check(input string tag, input logic [323:0] got, input logic [323:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [323:0] make_map(input int unsigned shift);
    logic [323:0] m;
    m = '0;
    for (int unsigned r = 0; r < 9; r++)
      for (int unsigned c = 0; c < 9; c++)
        m[(r*9+c)*4 +: 4] = 4'((r*3 + r/3 + c + shift) % 9 + 1);
    return m;
  endfunction

  task automatic do_load(input logic [323:0] m, input logic [161:0] v);
    selected_map = m;
    selected_visibility = v;
    load = 1'b1;
    tick();
    load = 1'b0;
    selected_map = '0;
    selected_visibility = '0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  task automatic do_write(input logic [3:0] v);
    write_value = v;
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic do_clear();
    clear_cell = 1'b1;
    tick();
    clear_cell = 1'b0;
  endtask

  task automatic do_move(input logic [1:0] dir);
    move_up    = (dir == 2'd0);
    move_down  = (dir == 2'd1);
    move_left  = (dir == 2'd2);
    move_right = (dir == 2'd3);
    tick();
    {move_up, move_down, move_left, move_right} = '0;
  endtask

  task automatic check_cursor(input string tag, input logic [3:0] r, input logic [3:0] c);
    check({tag, "_row"}, {320'b0, cursor_row}, {320'b0, r});
    check({tag, "_col"}, {320'b0, cursor_col}, {320'b0, c});
  endtask

  initial begin
    map_a = make_map(4);
    map_b = make_map(7);
    vis_all = '1;
    vis_hide0 = '1;
    vis_hide0[0] = 1'b0;
    mask_all = '1;
    mask_hide0 = '1;
    mask_hide0[0] = 1'b0;
    {load, move_up, move_down, move_left, move_right, write_en, clear_cell} = '0;
    write_value = '0;
    selected_map = '0;
    selected_visibility = '0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_board", board, '0);
    check("rst_mask", {243'b0, given_mask}, '0);
    check("rst_busy", {323'b0, busy}, '0);
    check("rst_solved", {323'b0, solved}, '0);
    check("rst_wrong", {317'b0, wrong_count}, '0);
    check_cursor("rst_cur", 4'd0, 4'd0);

    // Fully given map: busy for exactly 81 cycles, board equals the solution.
    do_load(map_a, vis_all);
    count_busy(n);
    check("load_busy_len", 324'(n), 324'd81);
    check("load_board", board, map_a);
    check("load_mask", {243'b0, given_mask}, {243'b0, mask_all});
    do_write(4'd3);
    check("given_write_board", board, map_a);
    check("given_write_busy", {323'b0, busy}, '0);
    tick();
    tick();
    check("given_write_busy2", {323'b0, busy}, '0);

    // Only cell 0 hidden (solution 5): wrong entry then correct entry.
    do_load(map_a, vis_hide0);
    count_busy(n);
    check("hide_busy_len", 324'(n), 324'd81);
    exp_board = map_a;
    exp_board[3:0] = 4'd0;
    check("hide_board", board, exp_board);
    check("hide_mask", {243'b0, given_mask}, {243'b0, mask_hide0});
    do_write(4'd3);
    exp_board[3:0] = 4'd3;
    check("w3_board_t1", board, exp_board);
    check("w3_busy_t1", {323'b0, busy}, 324'd1);
    repeat (80) tick();
    check("w3_busy_t81", {323'b0, busy}, 324'd1);
    check("w3_wrong_t81", {317'b0, wrong_count}, '0);
    tick();
    check("w3_busy_t82", {323'b0, busy}, '0);
    check("w3_wrong_t82", {317'b0, wrong_count}, 324'd1);
    check("w3_solved_t82", {323'b0, solved}, '0);
    do_write(4'd5);
    exp_board[3:0] = 4'd5;
    check("w5_board_t1", board, exp_board);
    repeat (80) tick();
    check("w5_solved_t81", {323'b0, solved}, '0);
    tick();
    check("w5_wrong_t82", {317'b0, wrong_count}, '0);
    check("w5_solved_t82", {323'b0, solved}, 324'd1);
    check("w5_busy_t82", {323'b0, busy}, '0);
    do_write(4'd7);
    check("solved_frozen", board, exp_board);
    check("solved_busy", {323'b0, busy}, '0);
    do_clear();
    check("solved_clear", board, exp_board);

    // Cursor wrap, exercised while solved (moves still accepted there).
    do_move(2'd0); check_cursor("up_wrap", 4'd8, 4'd0);
    do_move(2'd2); check_cursor("left_wrap", 4'd8, 4'd8);
    do_move(2'd3); check_cursor("right_wrap", 4'd8, 4'd0);
    do_move(2'd1); check_cursor("down_wrap", 4'd0, 4'd0);
    check("solved_hold", {323'b0, solved}, 324'd1);

    // Write and move in the same cycle: write wins, cursor stays.
    do_load(map_a, vis_hide0);
    count_busy(n);
    exp_board = map_a;
    exp_board[3:0] = 4'd0;
    move_up = 1'b1;
    do_write(4'd3);
    move_up = 1'b0;
    exp_board[3:0] = 4'd3;
    check("wm_board", board, exp_board);
    check_cursor("wm_cur", 4'd0, 4'd0);
    check("wm_busy", {323'b0, busy}, 324'd1);
    count_busy(n);
    check("wm_busy_len", 324'(n), 324'd81);
    check("wm_wrong", {317'b0, wrong_count}, 324'd1);

    // Illegal digits and clearing a given cell are dropped.
    do_write(4'd0);
    check("val0_board", board, exp_board);
    check("val0_busy", {323'b0, busy}, '0);
    do_write(4'd12);
    check("val12_board", board, exp_board);
    check("val12_busy", {323'b0, busy}, '0);
    do_move(2'd3);
    check_cursor("to_given", 4'd0, 4'd1);
    do_clear();
    check("clr_given_board", board, exp_board);
    check("clr_given_busy", {323'b0, busy}, '0);
    do_move(2'd2);
    do_clear();
    exp_board[3:0] = 4'd0;
    check("clr_board", board, exp_board);
    check("clr_busy", {323'b0, busy}, 324'd1);
    count_busy(n);
    check("clr_wrong", {317'b0, wrong_count}, '0);
    check("clr_solved", {323'b0, solved}, '0);

    // Load aborts an in-progress check.
    do_write(4'd4);
    repeat (39) tick();
    check("mid_check_busy", {323'b0, busy}, 324'd1);
    do_load(map_b, vis_all);
    count_busy(n);
    check("abort_busy_len", 324'(n), 324'd81);
    check("abort_board", board, map_b);
    check("abort_wrong", {317'b0, wrong_count}, '0);
    check("abort_solved", {323'b0, solved}, '0);

    // Reset in the middle of a load.
    do_load(map_a, vis_all);
    repeat (29) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rl_board", board, '0);
    check("rl_mask", {243'b0, given_mask}, '0);
    check("rl_busy", {323'b0, busy}, '0);
    check("rl_wrong", {317'b0, wrong_count}, '0);
    check("rl_solved", {323'b0, solved}, '0);
    check_cursor("rl_cur", 4'd0, 4'd0);
    do_move(2'd1);
    do_move(2'd3);
    check_cursor("idle_moves", 4'd0, 4'd0);
    do_write(4'd5);
    check("idle_write", board, '0);
    check("idle_busy", {323'b0, busy}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
